// File: rtl/mult_fu.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) with an issue-side start/busy handshake
// and a CDB request port that holds the result until it is granted.
module mult_fu #(
    parameter int BITS_PER_CYCLE = 2,
    parameter int PHYS_REG_W     = 6,
    parameter int ROB_IDX_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  start,
    input  logic [31:0]           op_a,
    input  logic [31:0]           op_b,
    input  logic [2:0]            funct3,
    input  logic [PHYS_REG_W-1:0] pd_in,
    input  logic [ROB_IDX_W-1:0]  rob_in,
    output logic                  busy,
    output logic                  cdb_valid,
    input  logic                  cdb_grant,
    output logic [31:0]           cdb_data,
    output logic [PHYS_REG_W-1:0] cdb_pd,
    output logic [ROB_IDX_W-1:0]  cdb_rob
);

    localparam int CALC_CYCLES = 32 / BITS_PER_CYCLE;
    localparam int CNT_W       = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CALC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [63:0]             mcand_reg;
    logic [31:0]             mplier_reg;
    logic [63:0]             acc_reg;
    logic                    sign_reg;
    logic                    hi_sel_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    cdb_valid_reg;
    logic [31:0]             cdb_data_reg;
    logic [PHYS_REG_W-1:0]   cdb_pd_reg;
    logic [ROB_IDX_W-1:0]    cdb_rob_reg;

    // Operand decode: div/rem encodings (funct3[2]) fall back to plain MUL.
    logic [2:0]  op_sel;
    logic        a_signed;
    logic        b_signed;
    logic        sa;
    logic        sb;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        op_sel   = funct3[2] ? 3'b000 : funct3;
        a_signed = (op_sel[1:0] != 2'b11);
        b_signed = !op_sel[1];
        sa       = a_signed & op_a[31];
        sb       = b_signed & op_b[31];
        // Magnitude of -2^31 is 0x80000000, which still fits as unsigned 32b.
        a_mag    = sa ? (~op_a + 32'd1) : op_a;
        b_mag    = sb ? (~op_b + 32'd1) : op_b;
    end

    // One shifted copy of the multiplicand per retired multiplier bit.
    logic [63:0] pp_terms [BITS_PER_CYCLE];
    logic [63:0] pp_sum;
    logic [63:0] acc_sum;
    logic [63:0] product;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
            assign pp_terms[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 64'd0;
        end
    endgenerate

    always_comb begin
        pp_sum = 64'd0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            pp_sum = pp_sum + pp_terms[i];
        end
        acc_sum = acc_reg + pp_sum;
        product = sign_reg ? (~acc_sum + 64'd1) : acc_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mcand_reg     <= 64'd0;
            mplier_reg    <= 32'd0;
            acc_reg       <= 64'd0;
            sign_reg      <= 1'b0;
            hi_sel_reg    <= 1'b0;
            cnt_reg       <= '0;
            cdb_valid_reg <= 1'b0;
            cdb_data_reg  <= 32'd0;
            cdb_pd_reg    <= '0;
            cdb_rob_reg   <= '0;
        end else if (flush) begin
            state_reg     <= IDLE;
            cdb_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg   <= {32'd0, a_mag};
                        mplier_reg  <= b_mag;
                        acc_reg     <= 64'd0;
                        sign_reg    <= sa ^ sb;
                        hi_sel_reg  <= (op_sel != 3'b000);
                        cnt_reg     <= CNT_LAST;
                        cdb_pd_reg  <= pd_in;
                        cdb_rob_reg <= rob_in;
                        state_reg   <= CALC;
                    end
                end
                CALC: begin
                    acc_reg    <= acc_sum;
                    mcand_reg  <= mcand_reg << BITS_PER_CYCLE;
                    mplier_reg <= mplier_reg >> BITS_PER_CYCLE;
                    if (cnt_reg == '0) begin
                        cdb_data_reg  <= hi_sel_reg ? product[63:32] : product[31:0];
                        cdb_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    if (cdb_grant) begin
                        cdb_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    cdb_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign cdb_valid = cdb_valid_reg;
    assign cdb_data  = cdb_data_reg;
    assign cdb_pd    = cdb_pd_reg;
    assign cdb_rob   = cdb_rob_reg;

    // Protocol checks on the issue side; neither affects the datapath.
    always @(posedge clk) begin
        if (rst_n && !flush && start && !busy) begin
            assert (!funct3[2])
            else $error("mult_fu: div/rem funct3 %0b issued to multiplier", funct3);
        end
        if (rst_n) begin
            assert (!(start && busy))
            else $warning("mult_fu: start while busy ignored");
        end
    end

endmodule

// File: tb/tb_mult_fu.sv
// Directed bench for mult_fu: default BITS_PER_CYCLE=2 instance plus 1- and 4-bit instances
// compared against a sign-extended 64b reference multiply.
module tb_mult_fu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [5:0]  pd_in = 6'd0;
    logic [4:0]  rob_in = 5'd0;

    logic        start = 1'b0, start1 = 1'b0, start4 = 1'b0;
    logic        grant = 1'b0, grant1 = 1'b0, grant4 = 1'b0;
    logic        busy, busy1, busy4;
    logic        cdb_valid, valid1, valid4;
    logic [31:0] cdb_data, data1, data4;
    logic [5:0]  cdb_pd, pd1, pd4;
    logic [4:0]  cdb_rob, rob1, rob4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mult_fu #(.BITS_PER_CYCLE(2), .PHYS_REG_W(6), .ROB_IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start),
        .op_a(op_a), .op_b(op_b), .funct3(funct3), .pd_in(pd_in), .rob_in(rob_in),
        .busy(busy), .cdb_valid(cdb_valid), .cdb_grant(grant),
        .cdb_data(cdb_data), .cdb_pd(cdb_pd), .cdb_rob(cdb_rob)
    );

    mult_fu #(.BITS_PER_CYCLE(1), .PHYS_REG_W(6), .ROB_IDX_W(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start1),
        .op_a(op_a), .op_b(op_b), .funct3(funct3), .pd_in(pd_in), .rob_in(rob_in),
        .busy(busy1), .cdb_valid(valid1), .cdb_grant(grant1),
        .cdb_data(data1), .cdb_pd(pd1), .cdb_rob(rob1)
    );

    mult_fu #(.BITS_PER_CYCLE(4), .PHYS_REG_W(6), .ROB_IDX_W(5)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start4),
        .op_a(op_a), .op_b(op_b), .funct3(funct3), .pd_in(pd_in), .rob_in(rob_in),
        .busy(busy4), .cdb_valid(valid4), .cdb_grant(grant4),
        .cdb_data(data4), .cdb_pd(pd4), .cdb_rob(rob4)
    );

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
        logic [63:0] ea, eb, p;
        ea = (f[1:0] != 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f[1] == 1'b0)    ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (f == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                         input logic [5:0] pd, input logic [4:0] rob);
        @(negedge clk);
        op_a = a; op_b = b; funct3 = f; pd_in = pd; rob_in = rob;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Edges counted from the start-sampling edge until cdb_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!cdb_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!cdb_valid) lat = -1;
    endtask

    task automatic grant_main();
        grant = 1'b1;
        @(posedge clk); #1;
        grant = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                         output logic [31:0] data, output int lat);
        issue(a, b, f, 6'd1, 5'd1);
        wait_valid(lat);
        data = cdb_data;
        $display("[TB] op f=%0b a=%h b=%h -> data=%h lat=%0d", f, a, b, data, lat);
        grant_main();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || cdb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy=%b cdb_valid=%b, required 0 0", busy, cdb_valid);
        end
        tests_run++;
        if (cdb_data !== 32'd0 || cdb_pd !== 6'd0 || cdb_rob !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_data: data=%h pd=%h rob=%h, required 0", cdb_data, cdb_pd, cdb_rob);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic bad_busy, bad_valid;
        issue(32'd7, 32'd6, 3'b000, 6'd37, 5'd19);
        bad_busy = (busy !== 1'b1);
        bad_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b1) bad_busy = 1'b1;
            if (cdb_valid !== (i == 16)) bad_valid = 1'b1;
        end
        $display("[TB] MUL 7*6 -> data=%h pd=%0d rob=%0d", cdb_data, cdb_pd, cdb_rob);
        tests_run++;
        if (bad_busy) begin
            tests_failed++;
            $display("FAIL mul_busy: busy dropped during CALC/DONE, required 1");
        end
        tests_run++;
        if (bad_valid) begin
            tests_failed++;
            $display("FAIL mul_latency: cdb_valid=%b after 16 edges, required first high at edge 16", cdb_valid);
        end
        tests_run++;
        if (cdb_data !== 32'h0000002A || cdb_pd !== 6'd37 || cdb_rob !== 5'd19) begin
            tests_failed++;
            $display("FAIL mul_result: data=%h pd=%0d rob=%0d, required 0000002a 37 19", cdb_data, cdb_pd, cdb_rob);
        end
        grant_main();
        tests_run++;
        if (busy !== 1'b0 || cdb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mul_release: busy=%b valid=%b, required 0 0", busy, cdb_valid);
        end
    endtask

    task automatic test_signed();
        logic [31:0] va [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h80000000};
        logic [31:0] vb [8] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'h00012345, 32'h7FFFFFFF, 32'h7FFFFFFF};
        logic [2:0]  vf [8] = '{3'b001, 3'b001, 3'b000, 3'b011, 3'b010, 3'b000, 3'b001, 3'b000};
        logic [31:0] ve [8] = '{32'h40000000, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFE,
                                32'hFFFFFFFF, 32'h00000000, 32'hC0000000, 32'h80000000};
        logic [31:0] d;
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_op(va[i], vb[i], vf[i], d, lat);
            tests_run++;
            if (d !== ve[i] || lat != 16) begin
                tests_failed++;
                $display("FAIL signed_%0d: data=%h lat=%0d, required %h 16", i, d, lat, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic bad;
        issue(32'd3, 32'd5, 3'b000, 6'd7, 5'd3);
        wait_valid(lat);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1; op_a = 32'd100; op_b = 32'd100;
            end else begin
                start = 1'b0;
            end
            if (cdb_valid !== 1'b1 || cdb_data !== 32'd15 || busy !== 1'b1) bad = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        $display("[TB] stall MUL 3*5 -> valid=%b data=%h", cdb_valid, cdb_data);
        tests_run++;
        if (bad || cdb_valid !== 1'b1 || cdb_data !== 32'd15 || cdb_rob !== 5'd3) begin
            tests_failed++;
            $display("FAIL stall_hold: valid=%b data=%h rob=%0d, required 1 0000000f 3 for 5 cycles",
                     cdb_valid, cdb_data, cdb_rob);
        end
        grant = 1'b1; start = 1'b1; op_a = 32'd2; op_b = 32'd21; rob_in = 5'd4; funct3 = 3'b000;
        @(posedge clk); #1;
        grant = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || cdb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL grant_cycle_start: busy=%b valid=%b, required 0 0", busy, cdb_valid);
        end
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_accept: busy=%b, required 1", busy);
        end
        wait_valid(lat);
        $display("[TB] b2b MUL 2*21 -> data=%h lat=%0d", cdb_data, lat);
        tests_run++;
        if (cdb_data !== 32'd42 || lat != 16 || cdb_rob !== 5'd4) begin
            tests_failed++;
            $display("FAIL b2b_result: data=%h lat=%0d rob=%0d, required 0000002a 16 4", cdb_data, lat, cdb_rob);
        end
        grant_main();
    endtask

    task automatic test_flush();
        logic bad;
        logic [31:0] d;
        int lat;
        issue(32'd1000, 32'd1000, 3'b000, 6'd2, 5'd2);
        repeat (7) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || cdb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_idle: busy=%b valid=%b, required 0 0", busy, cdb_valid);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (cdb_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL flush_no_valid: valid or busy rose after flush, required 0");
        end
        do_op(32'd9, 32'd9, 3'b000, d, lat);
        tests_run++;
        if (d !== 32'd81 || lat != 16) begin
            tests_failed++;
            $display("FAIL flush_restart: data=%h lat=%0d, required 00000051 16", d, lat);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        int lat;
        issue(32'd123, 32'd456, 3'b000, 6'd5, 5'd5);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || cdb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_calc: busy=%b valid=%b, required 0 0", busy, cdb_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_release: busy=%b, required 0", busy);
        end
        issue(32'd6, 32'd7, 3'b000, 6'd3, 5'd2);
        wait_valid(lat);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (cdb_valid !== 1'b0 || cdb_data !== 32'd0 || cdb_pd !== 6'd0 || cdb_rob !== 5'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_done: valid=%b data=%h pd=%h rob=%h busy=%b, required all 0",
                     cdb_valid, cdb_data, cdb_pd, cdb_rob, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'hFFFFFFF9, 32'd6, 3'b000, d, lat);
        tests_run++;
        if (d !== 32'hFFFFFFD6 || lat != 16) begin
            tests_failed++;
            $display("FAIL areset_recover: data=%h lat=%0d, required ffffffd6 16", d, lat);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] a, b, exp, d1, d4;
        logic [2:0]  f;
        int lat1, lat4;
        for (int n = 0; n < 10; n++) begin
            if (n == 0) begin
                a = 32'h80000000; b = 32'h80000000; f = 3'b001;
            end else if (n == 1) begin
                a = 32'h80000000; b = 32'hFFFFFFFF; f = 3'b010;
            end else begin
                a = $urandom; b = $urandom; f = 3'($urandom_range(0, 3));
            end
            exp = ref_mul(a, b, f);
            @(negedge clk);
            op_a = a; op_b = b; funct3 = f; pd_in = 6'(n); rob_in = 5'(n);
            start1 = 1'b1; start4 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0; start4 = 1'b0;
            lat1 = -1; lat4 = -1; d1 = 32'd0; d4 = 32'd0;
            for (int c = 1; c <= 80 && (lat1 < 0 || lat4 < 0); c++) begin
                @(posedge clk); #1;
                if (valid1 && lat1 < 0) begin lat1 = c; d1 = data1; end
                if (valid4 && lat4 < 0) begin lat4 = c; d4 = data4; end
            end
            $display("[TB] sweep f=%0b a=%h b=%h -> bpc1=%h/%0d bpc4=%h/%0d", f, a, b, d1, lat1, d4, lat4);
            tests_run++;
            if (d1 !== exp || lat1 != 32 || rob1 !== 5'(n)) begin
                tests_failed++;
                $display("FAIL sweep_bpc1_%0d: data=%h lat=%0d, required %h 32", n, d1, lat1, exp);
            end
            tests_run++;
            if (d4 !== exp || lat4 != 8 || rob4 !== 5'(n)) begin
                tests_failed++;
                $display("FAIL sweep_bpc4_%0d: data=%h lat=%0d, required %h 8", n, d4, lat4, exp);
            end
            grant1 = 1'b1; grant4 = 1'b1;
            @(posedge clk); #1;
            grant1 = 1'b0; grant4 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_signed();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
